fx3_wr_scheduler: RTL and testbench

//   Round-robin write scheduler that shares the FX3 slave-FIFO (2-bit address) bus between N_SRC

---
 rtl/fx3_wr_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_fx3_wr_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_wr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fx3_wr_scheduler                                           |
// | Description : Round-robin write scheduler sharing the FX3 slave-FIFO     |
// |               bus between N_SRC streaming sources. Source i writes to    |
// |               socket faddr = i. Each socket keeps its own packet         |
// |               position; full packets auto-commit, partial packets are    |
// |               committed with pktend_n on a flush request.                |
// | Optional    : FX3_WR_SCHED_ZLP_EN - when defined, a flush with an empty  |
// |               packet sends a zero-length packet (pktend_n, no slwr_n).   |
// |               When undefined, such a flush is acknowledged in IDLE with  |
// |               no bus activity.                                           |
// | Ports       : clk, reset        - clock / sync active-high reset         |
// |               src_data/valid/ready, src_flush/src_flush_ack - sources    |
// |               flag_rdy, flag_wm - FX3 flags A/B (registered once)        |
// |               fdata_o, fdata_oe, faddr, slwr_n, pktend_n,                |
// |               slcs_n, sloe_n, slrd_n - FX3 pins                          |
// |               busy, cur_src     - status                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fx3_wr_scheduler #(
  parameter int N_SRC     = 2,
  parameter int DW        = 32,
  parameter int BURST_LEN = 1024,
  parameter int FLAG_LAT  = 3,
  parameter int TURN      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic [N_SRC-1:0]    src_valid,
  output logic [N_SRC-1:0]    src_ready,
  input  logic [N_SRC-1:0]    src_flush,
  output logic [N_SRC-1:0]    src_flush_ack,
  input  logic                flag_rdy,
  input  logic                flag_wm,
  output logic [DW-1:0]       fdata_o,
  output logic                fdata_oe,
  output logic [1:0]          faddr,
  output logic                slwr_n,
  output logic                pktend_n,
  output logic                slcs_n,
  output logic                sloe_n,
  output logic                slrd_n,
  output logic                busy,
  output logic [1:0]          cur_src
);

  localparam int CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int TMAX = (FLAG_LAT > TURN) ? FLAG_LAT : TURN;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [TW-1:0] C_ADDR_TMR = TW'(FLAG_LAT - 1);
  localparam logic [TW-1:0] C_TURN_TMR = TW'(TURN - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_WAIT_FLAG = 3'd2,
    ST_WRITE     = 3'd3,
    ST_PKTEND    = 3'd4,
    ST_TURN      = 3'd5
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_cur;
  logic [SW-1:0]    r_rr;
  logic [CW-1:0]    r_cnt [N_SRC];
  logic [TW-1:0]    r_tmr;
  logic             r_flag_rdy_d;
  logic             r_flag_wm_d;
  logic [DW-1:0]    r_fdata;
  logic [1:0]       r_faddr;
  logic             r_slwr_n;
  logic             r_pktend_n;
  logic [N_SRC-1:0] r_flush_ack;

  logic [N_SRC-1:0] w_req;
  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt;
  logic             w_idle_ack;
  logic             w_cur_valid;
  logic             w_cur_flush;
  logic [CW-1:0]    w_cur_cnt;
  logic             w_cnt_zero;
  logic             w_cnt_last;
  logic [DW-1:0]    w_cur_data;
  logic             w_accept;

  // A flush that was just acknowledged is masked for one cycle so the
  // source has time to drop its level request before it is seen again.
  assign w_req       = src_valid | (src_flush & ~r_flush_ack);

  assign w_cur_valid = src_valid[r_cur];
  assign w_cur_flush = src_flush[r_cur];
  assign w_cur_cnt   = r_cnt[r_cur];
  assign w_cnt_zero  = (w_cur_cnt == '0);
  assign w_cnt_last  = (w_cur_cnt == C_CNT_LAST);
  assign w_cur_data  = src_data[r_cur*DW +: DW];

  // The counter wraps at BURST_LEN, so it is always below BURST_LEN here.
  // Reset gating keeps a word from being handed over on a reset edge.
  assign w_accept = (r_state == ST_WRITE) & w_cur_valid & r_flag_wm_d & ~reset;

  // Empty-packet flush handled directly in IDLE when ZLPs are not sent.
`ifdef FX3_WR_SCHED_ZLP_EN
  assign w_idle_ack = 1'b0;
`else
  assign w_idle_ack = ~src_valid[w_gnt] & src_flush[w_gnt] & (r_cnt[w_gnt] == '0);
`endif

  // Round-robin pick: first requester starting at rr+1. Iterating from the
  // farthest candidate down lets the nearest one win by last assignment.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (w_req[(int'(r_rr) + k) % N_SRC]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SW'((int'(r_rr) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    src_ready        = '0;
    src_ready[r_cur] = w_accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_rr         <= '0;
      r_tmr        <= '0;
      r_flag_rdy_d <= 1'b0;
      r_flag_wm_d  <= 1'b0;
      r_fdata      <= '0;
      r_faddr      <= '0;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_flush_ack  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_flag_rdy_d <= flag_rdy;
      r_flag_wm_d  <= flag_wm;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_flush_ack  <= '0;

      // Accepted word goes to the pins on the next cycle.
      if (w_accept) begin
        r_fdata      <= w_cur_data;
        r_slwr_n     <= 1'b0;
        r_cnt[r_cur] <= w_cnt_last ? '0 : w_cur_cnt + CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld && w_idle_ack) begin
            r_flush_ack[w_gnt] <= 1'b1;
          end else if (w_gnt_vld) begin
            r_cur   <= w_gnt;
            r_faddr <= 2'(w_gnt);
            r_tmr   <= C_ADDR_TMR;
            r_state <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (r_tmr == '0) begin
            r_state <= ST_WAIT_FLAG;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end

        ST_WAIT_FLAG: begin
`ifdef FX3_WR_SCHED_ZLP_EN
          if (r_flag_rdy_d && w_cur_flush && !w_cur_valid && w_cnt_zero) begin
            r_pktend_n         <= 1'b0;
            r_flush_ack[r_cur] <= 1'b1;
            r_state            <= ST_PKTEND;
          end else
`endif
          if (r_flag_rdy_d && r_flag_wm_d) begin
            r_state <= ST_WRITE;
          end else if (w_cur_flush && !w_cur_valid && !w_cnt_zero) begin
            r_pktend_n         <= 1'b0;
            r_flush_ack[r_cur] <= 1'b1;
            r_cnt[r_cur]       <= '0;
            r_state            <= ST_PKTEND;
          end
        end

        ST_WRITE: begin
          if (w_accept && w_cnt_last) begin
            // Full packet: FX3 commits it on its own.
            r_tmr   <= C_TURN_TMR;
            r_state <= ST_TURN;
          end else if (!r_flag_wm_d) begin
            r_tmr   <= C_TURN_TMR;
            r_state <= ST_TURN;
          end else if (!w_cur_valid && w_cur_flush && !w_cnt_zero) begin
            // The last word is on the pins this cycle; pktend follows it.
            r_pktend_n         <= 1'b0;
            r_flush_ack[r_cur] <= 1'b1;
            r_cnt[r_cur]       <= '0;
            r_state            <= ST_PKTEND;
          end else if (!w_cur_valid) begin
            r_tmr   <= C_TURN_TMR;
            r_state <= ST_TURN;
          end
        end

        ST_PKTEND: begin
          r_tmr   <= C_TURN_TMR;
          r_state <= ST_TURN;
        end

        ST_TURN: begin
          if (r_tmr == '0) begin
            r_rr    <= r_cur;
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fdata_o       = r_fdata;
  assign fdata_oe      = ~r_slwr_n;
  assign faddr         = r_faddr;
  assign slwr_n        = r_slwr_n;
  assign pktend_n      = r_pktend_n;
  assign src_flush_ack = r_flush_ack;
  assign slcs_n        = 1'b0;
  assign sloe_n        = 1'b1;
  assign slrd_n        = 1'b1;
  assign busy          = (r_state != ST_IDLE);
  assign cur_src       = 2'(r_cur);

endmodule
`default_nettype wire

// File: tb/tb_fx3_wr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fx3_wr_scheduler                                        |
// | Description : Directed self-checking bench for fx3_wr_scheduler with     |
// |               BURST_LEN = 16 and two sources. Sources are counters whose |
// |               words carry {source index, sequence number}; a negedge     |
// |               monitor logs every FX3 write, pktend and flush ack.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fx3_wr_scheduler;

  localparam int N_SRC     = 2;
  localparam int DW        = 32;
  localparam int BURST_LEN = 16;
  localparam int FLAG_LAT  = 3;
  localparam int TURN      = 4;
  // Last write of a burst to first write of the next: TURN cycles, one IDLE,
  // FLAG_LAT ADDR cycles, one WAIT_FLAG, then the accept cycle before output.
  localparam int GAP       = TURN + FLAG_LAT + 3;

  logic                clk;
  logic                reset;
  logic [N_SRC*DW-1:0] src_data;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_ready;
  logic [N_SRC-1:0]    src_flush;
  logic [N_SRC-1:0]    src_flush_ack;
  logic                flag_rdy;
  logic                flag_wm;
  logic [DW-1:0]       fdata_o;
  logic                fdata_oe;
  logic [1:0]          faddr;
  logic                slwr_n, pktend_n, slcs_n, sloe_n, slrd_n, busy;
  logic [1:0]          cur_src;

  fx3_wr_scheduler #(
    .N_SRC(N_SRC), .DW(DW), .BURST_LEN(BURST_LEN), .FLAG_LAT(FLAG_LAT), .TURN(TURN)
  ) dut (
    .clk(clk), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_flush(src_flush), .src_flush_ack(src_flush_ack),
    .flag_rdy(flag_rdy), .flag_wm(flag_wm),
    .fdata_o(fdata_o), .fdata_oe(fdata_oe), .faddr(faddr),
    .slwr_n(slwr_n), .pktend_n(pktend_n),
    .slcs_n(slcs_n), .sloe_n(sloe_n), .slrd_n(slrd_n),
    .busy(busy), .cur_src(cur_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: valid while enabled and below its word limit.
  int         seq [N_SRC] = '{0, 0};
  int         lim [N_SRC] = '{0, 0};
  logic [N_SRC-1:0] en;

  always_comb begin
    src_data  = '0;
    src_valid = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_data[i*DW +: DW] = {8'(i), seq[i][23:0]};
      src_valid[i]         = en[i] && (seq[i] < lim[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) seq[i] <= seq[i] + 1;
    end
  end

  // Bus monitor.
  logic [DW-1:0] wr_data [$];
  logic [1:0]    wr_addr [$];
  int            wr_cyc  [$];
  int cyc = 0, n_pkt = 0, last_pkt_cyc = 0, n_ack = 0, last_ack_cyc = 0;
  int n_overlap = 0, n_oe_bad = 0, n_busy = 0;

  always @(negedge clk) begin
    cyc++;
    if (!slwr_n) begin
      wr_data.push_back(fdata_o);
      wr_addr.push_back(faddr);
      wr_cyc.push_back(cyc);
    end
    if (!pktend_n) begin
      n_pkt++;
      last_pkt_cyc = cyc;
      if (!slwr_n) n_overlap++;
    end
    if (src_flush_ack != '0) begin
      n_ack++;
      last_ack_cyc = cyc;
    end
    if (fdata_oe !== ~slwr_n) n_oe_bad++;
    if (busy) n_busy++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (wr_data.size() >= target && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (src_flush_ack[idx]) begin
        ok = 1'b1;
        src_flush[idx] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (slwr_n !== 1'b1)      begin n_errors++; $display("FAIL rst_slwr_n: got %b expected 1", slwr_n); end
    n_checks++; if (pktend_n !== 1'b1)    begin n_errors++; $display("FAIL rst_pktend_n: got %b expected 1", pktend_n); end
    n_checks++; if (fdata_oe !== 1'b0)    begin n_errors++; $display("FAIL rst_fdata_oe: got %b expected 0", fdata_oe); end
    n_checks++; if (fdata_o !== '0)       begin n_errors++; $display("FAIL rst_fdata_o: got %h expected 0", fdata_o); end
    n_checks++; if (faddr !== 2'd0)       begin n_errors++; $display("FAIL rst_faddr: got %0d expected 0", faddr); end
    n_checks++; if (src_ready !== '0)     begin n_errors++; $display("FAIL rst_src_ready: got %b expected 0", src_ready); end
    n_checks++; if (src_flush_ack !== '0) begin n_errors++; $display("FAIL rst_flush_ack: got %b expected 0", src_flush_ack); end
    n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (cur_src !== 2'd0)     begin n_errors++; $display("FAIL rst_cur_src: got %0d expected 0", cur_src); end
    n_checks++; if (slcs_n !== 1'b0)      begin n_errors++; $display("FAIL slcs_n: got %b expected 0", slcs_n); end
    n_checks++; if (sloe_n !== 1'b1)      begin n_errors++; $display("FAIL sloe_n: got %b expected 1", sloe_n); end
    n_checks++; if (slrd_n !== 1'b1)      begin n_errors++; $display("FAIL slrd_n: got %b expected 1", slrd_n); end
    reset = 1'b0;
  endtask

  task automatic test_full_packet();
    int base, pk0, s0, bad;
    bit ok;
    logic [DW-1:0] exp;
    base = wr_data.size(); pk0 = n_pkt; s0 = seq[0];
    lim[0] = s0 + BURST_LEN; en = 2'b01;
    wait_done(base + BURST_LEN, 300, ok);
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL full_timeout: got %0d writes expected %0d", wr_data.size() - base, BURST_LEN); end
    n_checks++; if (wr_data.size() - base !== BURST_LEN) begin n_errors++; $display("FAIL full_count: got %0d expected %0d", wr_data.size() - base, BURST_LEN); end
    if (ok) begin
      bad = 0;
      for (int k = 0; k < BURST_LEN; k++) begin
        exp = {8'd0, 24'(s0 + k)};
        if (wr_data[base+k] !== exp || wr_addr[base+k] !== 2'd0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL full_data: got %0d bad words expected 0", bad); end
      n_checks++; if (wr_cyc[base+BURST_LEN-1] - wr_cyc[base] !== BURST_LEN - 1) begin n_errors++; $display("FAIL full_consecutive: got span %0d expected %0d", wr_cyc[base+BURST_LEN-1] - wr_cyc[base], BURST_LEN - 1); end
    end
    n_checks++; if (n_pkt - pk0 !== 0) begin n_errors++; $display("FAIL full_pktend: got %0d pulses expected 0", n_pkt - pk0); end
    en = '0;
  endtask

  task automatic test_flush_partial();
    int base, pk0, ak0, ov0, s0, bad;
    bit ok, ok2;
    logic [DW-1:0] exp;
    base = wr_data.size(); pk0 = n_pkt; ak0 = n_ack; ov0 = n_overlap; s0 = seq[0];
    lim[0] = s0 + 10; en = 2'b01; src_flush[0] = 1'b1;
    wait_ack(0, 300, ok);
    wait_done(base + 10, 100, ok2);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL flush_ack_timeout: got no ack expected ack"); end
    n_checks++; if (wr_data.size() - base !== 10) begin n_errors++; $display("FAIL flush_count: got %0d writes expected 10", wr_data.size() - base); end
    n_checks++; if (n_pkt - pk0 !== 1) begin n_errors++; $display("FAIL flush_pktend: got %0d pulses expected 1", n_pkt - pk0); end
    n_checks++; if (n_ack - ak0 !== 1) begin n_errors++; $display("FAIL flush_ack_count: got %0d expected 1", n_ack - ak0); end
    n_checks++; if (n_overlap - ov0 !== 0) begin n_errors++; $display("FAIL flush_overlap: got %0d pktend-with-slwr cycles expected 0", n_overlap - ov0); end
    if (ok && ok2) begin
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        exp = {8'd0, 24'(s0 + k)};
        if (wr_data[base+k] !== exp) bad++;
      end
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL flush_data: got %0d bad words expected 0", bad); end
      n_checks++; if (last_pkt_cyc !== wr_cyc[base+9] + 1) begin n_errors++; $display("FAIL flush_pktend_timing: got cycle %0d expected %0d", last_pkt_cyc, wr_cyc[base+9] + 1); end
      n_checks++; if (last_ack_cyc !== last_pkt_cyc) begin n_errors++; $display("FAIL flush_ack_timing: got cycle %0d expected %0d", last_ack_cyc, last_pkt_cyc); end
    end
    en = '0;
  endtask

  task automatic test_round_robin();
    int base, pk0, bad, e, idx;
    int s [N_SRC];
    bit ok;
    logic [DW-1:0] exp;
    base = wr_data.size(); pk0 = n_pkt;
    for (int i = 0; i < N_SRC; i++) begin
      s[i]   = seq[i];
      lim[i] = s[i] + 2 * BURST_LEN;
    end
    en = 2'b11;
    wait_done(base + 4 * BURST_LEN, 1500, ok);
    #1;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rr_timeout: got %0d writes expected %0d", wr_data.size() - base, 4 * BURST_LEN); end
    n_checks++; if (wr_data.size() - base !== 4 * BURST_LEN) begin n_errors++; $display("FAIL rr_count: got %0d expected %0d", wr_data.size() - base, 4 * BURST_LEN); end
    if (ok) begin
      // rr points at source 0 after the previous tests, so source 1 goes first.
      for (int g = 0; g < 4; g++) begin
        e   = (g % 2 == 0) ? 1 : 0;
        bad = 0;
        for (int k = 0; k < BURST_LEN; k++) begin
          idx = base + g * BURST_LEN + k;
          exp = {8'(e), 24'(s[e] + (g / 2) * BURST_LEN + k)};
          if (wr_addr[idx] !== 2'(e) || wr_data[idx] !== exp) bad++;
        end
        if (wr_cyc[base+g*BURST_LEN+BURST_LEN-1] - wr_cyc[base+g*BURST_LEN] != BURST_LEN - 1) bad++;
        if (g > 0 && wr_cyc[base+g*BURST_LEN] - wr_cyc[base+g*BURST_LEN-1] != GAP) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rr_grant%0d: got %0d bad words/gaps for source %0d expected 0", g, bad, e); end
      end
    end
    n_checks++; if (n_pkt - pk0 !== 0) begin n_errors++; $display("FAIL rr_pktend: got %0d pulses expected 0", n_pkt - pk0); end
    en = '0;
  endtask

  task automatic test_wm_drop();
    int base, pk0, s0, bad, n_first;
    bit ok, dropped;
    logic [DW-1:0] exp;
    base = wr_data.size(); pk0 = n_pkt; s0 = seq[0];
    lim[0] = s0 + BURST_LEN; en = 2'b01; dropped = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (wr_data.size() - base >= 5) begin
        flag_wm = 1'b0;
        dropped = 1'b1;
        break;
      end
    end
    repeat (30) @(negedge clk);
    #1;
    n_first = wr_data.size() - base;
    n_checks++; if (!dropped) begin n_errors++; $display("FAIL wm_timeout: got %0d writes expected 5 before drop", n_first); end
    // Drop seen with 5 words out; the word accepted in that cycle still goes.
    n_checks++; if (n_first !== 6) begin n_errors++; $display("FAIL wm_first_burst: got %0d writes expected 6", n_first); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL wm_regrant_wait: got busy %b expected 1", busy); end
    flag_wm = 1'b1;
    wait_done(base + BURST_LEN, 300, ok);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (wr_data.size() - base - n_first !== 10) begin n_errors++; $display("FAIL wm_second_burst: got %0d writes expected 10", wr_data.size() - base - n_first); end
    if (ok && n_first == 6) begin
      bad = 0;
      for (int k = 0; k < BURST_LEN; k++) begin
        exp = {8'd0, 24'(s0 + k)};
        if (wr_data[base+k] !== exp || wr_addr[base+k] !== 2'd0) bad++;
      end
      if (wr_cyc[base+BURST_LEN-1] - wr_cyc[base+6] != 9) bad++;
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL wm_data: got %0d bad words/gaps expected 0", bad); end
    end
    n_checks++; if (n_pkt - pk0 !== 0) begin n_errors++; $display("FAIL wm_pktend: got %0d pulses expected 0", n_pkt - pk0); end
    en = '0;
  endtask

  task automatic test_flush_zero();
    int base, pk0, ak0, bz0, ov0;
    int exp_pkt;
    bit ok;
`ifdef FX3_WR_SCHED_ZLP_EN
    exp_pkt = 1;
`else
    exp_pkt = 0;
`endif
    base = wr_data.size(); pk0 = n_pkt; ak0 = n_ack; bz0 = n_busy; ov0 = n_overlap;
    en = '0; src_flush[0] = 1'b1;
    wait_ack(0, 100, ok);
    repeat (15) @(negedge clk);
    #1;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL zero_ack_timeout: got no ack expected ack"); end
    n_checks++; if (n_ack - ak0 !== 1) begin n_errors++; $display("FAIL zero_ack_count: got %0d expected 1", n_ack - ak0); end
    n_checks++; if (wr_data.size() - base !== 0) begin n_errors++; $display("FAIL zero_writes: got %0d expected 0", wr_data.size() - base); end
    n_checks++; if (n_pkt - pk0 !== exp_pkt) begin n_errors++; $display("FAIL zero_pktend: got %0d expected %0d", n_pkt - pk0, exp_pkt); end
    n_checks++; if (n_overlap - ov0 !== 0) begin n_errors++; $display("FAIL zero_overlap: got %0d expected 0", n_overlap - ov0); end
    n_checks++; if ((n_busy - bz0 != 0) !== (exp_pkt == 1)) begin n_errors++; $display("FAIL zero_busy: got %0d busy cycles, expected nonzero=%0d", n_busy - bz0, exp_pkt); end
  endtask

  task automatic test_reset_midburst();
    int base, pk0, s0, bad;
    bit ok, hit;
    logic [DW-1:0] exp;
    base = wr_data.size(); hit = 1'b0;
    lim[0] = seq[0] + BURST_LEN; en = 2'b01;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (wr_data.size() - base >= 3) begin hit = 1'b1; break; end
    end
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (!hit) begin n_errors++; $display("FAIL rstmid_timeout: got %0d writes expected 3", wr_data.size() - base); end
    n_checks++; if (slwr_n !== 1'b1)   begin n_errors++; $display("FAIL rstmid_slwr_n: got %b expected 1", slwr_n); end
    n_checks++; if (fdata_oe !== 1'b0) begin n_errors++; $display("FAIL rstmid_oe: got %b expected 0", fdata_oe); end
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (src_ready !== '0)  begin n_errors++; $display("FAIL rstmid_ready: got %b expected 0", src_ready); end
    @(negedge clk); #1;
    reset = 1'b0;
    base = wr_data.size(); pk0 = n_pkt; s0 = seq[0];
    lim[0] = s0 + BURST_LEN;
    wait_done(base + BURST_LEN, 300, ok);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (wr_data.size() - base !== BURST_LEN) begin n_errors++; $display("FAIL rstmid_count: got %0d expected %0d", wr_data.size() - base, BURST_LEN); end
    if (ok) begin
      bad = 0;
      for (int k = 0; k < BURST_LEN; k++) begin
        exp = {8'd0, 24'(s0 + k)};
        if (wr_data[base+k] !== exp) bad++;
      end
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rstmid_data: got %0d bad words expected 0", bad); end
      // A counter left over from before reset would split this into two bursts.
      n_checks++; if (wr_cyc[base+BURST_LEN-1] - wr_cyc[base] !== BURST_LEN - 1) begin n_errors++; $display("FAIL rstmid_counter: got span %0d expected %0d", wr_cyc[base+BURST_LEN-1] - wr_cyc[base], BURST_LEN - 1); end
    end
    n_checks++; if (n_pkt - pk0 !== 0) begin n_errors++; $display("FAIL rstmid_pktend: got %0d expected 0", n_pkt - pk0); end
    n_checks++; if (n_oe_bad !== 0) begin n_errors++; $display("FAIL oe_tracks_slwr: got %0d bad cycles expected 0", n_oe_bad); end
    en = '0;
  endtask

  initial begin
    reset     = 1'b1;
    en        = '0;
    src_flush = '0;
    flag_rdy  = 1'b1;
    flag_wm   = 1'b1;
    test_reset();
    test_full_packet();
    test_flush_partial();
    test_round_robin();
    test_wm_drop();
    test_flush_zero();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
